memory_access: RTL and testbench

- Pipeline stage directly downstream of the execute stage.
- Consumes the registered ALU result, destination register and instruction info, and performs data-memory loads and stores over a request/grant/response bus.
- Byte-enables and write data are generated for stores; load data is aligned and sign/zero-extended.
- Presents a write-back bundle to the write-back stage using the same valid/ready pipeline handshake as the rest of the core.

---
 rtl/core_package.sv | 50 +++++
 rtl/memory_access_load_extend.sv | 29 ++
 rtl/memory_access.sv | 175 +++++++++++++++++
 tb/tb_memory_access.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_package.sv
// Shared core definitions for the memory-access stage: opcodes, funct3 codes,
// FSM state encodings and small helpers for byte-enable/write-data generation.
package core_package;

  typedef enum logic [6:0] {
    OPCODE_LOAD   = 7'b0000011,
    OPCODE_OP_IMM = 7'b0010011,
    OPCODE_STORE  = 7'b0100011,
    OPCODE_OP     = 7'b0110011,
    OPCODE_LUI    = 7'b0110111,
    OPCODE_SYSTEM = 7'b1110011
  } opcode_e;

  typedef logic [1:0] mem_state_e;
  localparam mem_state_e IDLE      = 2'd0;
  localparam mem_state_e REQ       = 2'd1;
  localparam mem_state_e WAIT_RESP = 2'd2;
  localparam mem_state_e OUT       = 2'd3;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // size is funct3[1:0]: 00 byte, 01 half, 10 word
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    return (size == 2'b01 && a[0]) || (size == 2'b10 && a != 2'b00);
  endfunction

  function automatic logic [3:0] access_be(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_load_extend.sv
// Load alignment: picks the addressed byte/half lane out of the response word
// and sign- or zero-extends it according to funct3.
module load_extend
  import core_package::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[8*addr_lo +: 8];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    case (funct3)
      LB:      data = {{24{byte_sel[7]}}, byte_sel};
      LH:      data = {{16{half_sel[15]}}, half_sel};
      LBU:     data = {24'd0, byte_sel};
      LHU:     data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage: loads/stores over a req/gnt/rvalid bus and a
// valid/ready write-back bundle. Optional bus timeout under MEM_TIMEOUT_EN.
module memory_access
  import core_package::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prev_valid_i,
  output logic              self_ready_o,
  output logic              self_valid_o,
  input  logic              next_ready_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [31:0]       result_i,
  input  logic [31:0]       store_data_i,
  input  logic [4:0]        rd_i,
  input  logic              csr_w_en_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [3:0]        dmem_be_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i,
  output logic [31:0]       wb_data_o,
  output logic [4:0]        rd_o,
  output logic              reg_w_en_o,
  output logic              csr_w_en_o,
`ifdef MEM_TIMEOUT_EN
  output logic              bus_err_o,
`endif
  output logic              misaligned_o
);

  mem_state_e  state_reg;
  logic [6:0]  opcode_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] addr_reg;
  logic [31:0] store_data_reg;
  logic [31:0] wb_data_reg;
  logic [4:0]  rd_reg;
  logic        reg_w_en_reg;
  logic        csr_w_en_reg;
  logic        misaligned_reg;
  logic [31:0] load_value;
  logic        in_req;
  logic        is_store_reg;
  logic        accept;
  logic        in_is_mem;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_reg;
  logic             bus_err_reg;
  logic             expired;
  assign expired   = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus_err_o = bus_err_reg;
`endif

  load_extend u_load_extend (
    .addr_lo (addr_reg[1:0]),
    .funct3  (funct3_reg),
    .rdata   (dmem_rdata_i),
    .data    (load_value)
  );

  assign in_req       = (state_reg == REQ);
  assign is_store_reg = (opcode_reg == OPCODE_STORE);
  assign in_is_mem    = (opcode_i == OPCODE_LOAD) || (opcode_i == OPCODE_STORE);

  // OUT hands the bundle over and takes the next instruction in the same edge
  assign self_ready_o = (state_reg == IDLE) || (state_reg == OUT && next_ready_i);
  assign accept       = prev_valid_i && self_ready_o;
  assign self_valid_o = (state_reg == OUT);

  assign dmem_req_o   = in_req;
  assign dmem_we_o    = in_req && is_store_reg;
  assign dmem_be_o    = in_req ? access_be(funct3_reg[1:0], addr_reg[1:0]) : 4'b0000;
  assign dmem_addr_o  = in_req ? {addr_reg[ADDR_W-1:2], 2'b00} : '0;
  assign dmem_wdata_o = (in_req && is_store_reg) ? store_wdata(funct3_reg[1:0], store_data_reg) : 32'd0;

  assign wb_data_o    = wb_data_reg;
  assign rd_o         = rd_reg;
  assign reg_w_en_o   = reg_w_en_reg;
  assign csr_w_en_o   = csr_w_en_reg;
  assign misaligned_o = misaligned_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      opcode_reg     <= 7'd0;
      funct3_reg     <= 3'd0;
      addr_reg       <= 32'd0;
      store_data_reg <= 32'd0;
      wb_data_reg    <= 32'd0;
      rd_reg         <= 5'd0;
      reg_w_en_reg   <= 1'b0;
      csr_w_en_reg   <= 1'b0;
      misaligned_reg <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_reg        <= '0;
      bus_err_reg    <= 1'b0;
`endif
    end else begin
`ifdef MEM_TIMEOUT_EN
      cnt_reg <= '0;
`endif
      if (accept) begin
        opcode_reg     <= opcode_i;
        funct3_reg     <= funct3_i;
        addr_reg       <= result_i;
        store_data_reg <= store_data_i;
        rd_reg         <= rd_i;
        csr_w_en_reg   <= csr_w_en_i;
        wb_data_reg    <= result_i;
`ifdef MEM_TIMEOUT_EN
        bus_err_reg    <= 1'b0;
`endif
        if (!in_is_mem) begin
          reg_w_en_reg   <= (rd_i != 5'd0);
          misaligned_reg <= 1'b0;
          state_reg      <= OUT;
        end else if (is_misaligned(funct3_i[1:0], result_i[1:0])) begin
          reg_w_en_reg   <= 1'b0;
          misaligned_reg <= 1'b1;
          state_reg      <= OUT;
        end else begin
          reg_w_en_reg   <= 1'b0;
          misaligned_reg <= 1'b0;
          state_reg      <= REQ;
        end
      end else begin
        case (state_reg)
          REQ: begin
            if (dmem_gnt_i) begin
              state_reg <= WAIT_RESP;
`ifdef MEM_TIMEOUT_EN
            end else if (expired) begin
              bus_err_reg <= 1'b1;
              state_reg   <= OUT;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
`endif
            end
          end
          WAIT_RESP: begin
            if (dmem_rvalid_i) begin
              if (!is_store_reg) begin
                wb_data_reg  <= load_value;
                reg_w_en_reg <= (rd_reg != 5'd0);
              end
              state_reg <= OUT;
`ifdef MEM_TIMEOUT_EN
            end else if (expired) begin
              bus_err_reg <= 1'b1;
              state_reg   <= OUT;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
`endif
            end
          end
          OUT: begin
            if (next_ready_i) state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed, table-driven bench for memory_access with a simple bus responder,
// plus hand sequences for backpressure, back-to-back accept and mid-access reset.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        prev_valid_i, self_ready_o, self_valid_o, next_ready_i;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [31:0] result_i, store_data_i;
  logic [4:0]  rd_i;
  logic        csr_w_en_i;
  logic        dmem_req_o, dmem_we_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic [31:0] wb_data_o;
  logic [4:0]  rd_o;
  logic        reg_w_en_o, csr_w_en_o, misaligned_o;
`ifdef MEM_TIMEOUT_EN
  logic        bus_err_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  memory_access dut (
    .clk           (clk),
    .reset         (reset),
    .prev_valid_i  (prev_valid_i),
    .self_ready_o  (self_ready_o),
    .self_valid_o  (self_valid_o),
    .next_ready_i  (next_ready_i),
    .opcode_i      (opcode_i),
    .funct3_i      (funct3_i),
    .result_i      (result_i),
    .store_data_i  (store_data_i),
    .rd_i          (rd_i),
    .csr_w_en_i    (csr_w_en_i),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_be_o     (dmem_be_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .wb_data_o     (wb_data_o),
    .rd_o          (rd_o),
    .reg_w_en_o    (reg_w_en_o),
    .csr_w_en_o    (csr_w_en_o),
`ifdef MEM_TIMEOUT_EN
    .bus_err_o     (bus_err_o),
`endif
    .misaligned_o  (misaligned_o)
  );

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] res;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          gnt_delay;
    logic        exp_req;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wb;
    logic        chk_wb;
    logic        exp_wen;
    logic        exp_mis;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] res,
                              input logic [31:0] sdata, input logic [4:0] rd, input logic [31:0] rdata,
                              input int gd, input logic er, input logic ew, input logic [3:0] eb,
                              input logic [31:0] ewd, input logic [31:0] ewb, input logic cwb,
                              input logic ewen, input logic emis);
    vec_t v;
    v.op = op; v.f3 = f3; v.res = res; v.sdata = sdata; v.rd = rd; v.rdata = rdata;
    v.gnt_delay = gd; v.exp_req = er; v.exp_we = ew; v.exp_be = eb; v.exp_wdata = ewd;
    v.exp_wb = ewb; v.chk_wb = cwb; v.exp_wen = ewen; v.exp_mis = emis;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive_in(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] res,
                          input logic [31:0] sdata, input logic [4:0] rd);
    prev_valid_i = 1'b1;
    opcode_i     = op;
    funct3_i     = f3;
    result_i     = res;
    store_data_i = sdata;
    rd_i         = rd;
    csr_w_en_i   = rd[0];
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    bit   saw_req, resp_sent;
    int   wait_cnt, cyc;
    v = vecs[idx];
    saw_req = 0; resp_sent = 0; wait_cnt = 0; cyc = 0;
    @(negedge clk);
    drive_in(v.op, v.f3, v.res, v.sdata, v.rd);
    @(negedge clk);
    prev_valid_i = 1'b0;
    while (!self_valid_o && cyc < 100) begin
      dmem_gnt_i = 1'b0;
      dmem_rvalid_i = 1'b0;
      if (dmem_req_o) begin
        check($sformatf("v%0d be", idx), {28'd0, dmem_be_o}, {28'd0, v.exp_be});
        check($sformatf("v%0d we", idx), {31'd0, dmem_we_o}, {31'd0, v.exp_we});
        check($sformatf("v%0d addr", idx), dmem_addr_o, {v.res[31:2], 2'b00});
        check($sformatf("v%0d ready_in_req", idx), {31'd0, self_ready_o}, 32'd0);
        if (v.exp_we) check($sformatf("v%0d wdata", idx), dmem_wdata_o, v.exp_wdata);
        saw_req = 1;
        if (wait_cnt == v.gnt_delay) dmem_gnt_i = 1'b1;
        else wait_cnt++;
      end else if (saw_req && !resp_sent) begin
        check($sformatf("v%0d ready_in_wait", idx), {31'd0, self_ready_o}, 32'd0);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = v.rdata;
        resp_sent = 1;
      end
      @(negedge clk);
      cyc++;
    end
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b0;
    check($sformatf("v%0d valid", idx), {31'd0, self_valid_o}, 32'd1);
    check($sformatf("v%0d req_seen", idx), {31'd0, saw_req}, {31'd0, v.exp_req});
    check($sformatf("v%0d wen", idx), {31'd0, reg_w_en_o}, {31'd0, v.exp_wen});
    check($sformatf("v%0d mis", idx), {31'd0, misaligned_o}, {31'd0, v.exp_mis});
    check($sformatf("v%0d rd", idx), {27'd0, rd_o}, {27'd0, v.rd});
    check($sformatf("v%0d csr", idx), {31'd0, csr_w_en_o}, {31'd0, v.rd[0]});
    if (v.chk_wb) check($sformatf("v%0d wb", idx), wb_data_o, v.exp_wb);
    $display("txn %0d op=%02h f3=%0d res=%08h req=%0d wb=%08h wen=%0d mis=%0d cycles=%0d",
             idx, v.op, v.f3, v.res, saw_req, wb_data_o, reg_w_en_o, misaligned_o, cyc);
    next_ready_i = 1'b1;
    @(negedge clk);
    next_ready_i = 1'b0;
    check($sformatf("v%0d drained", idx), {31'd0, self_valid_o}, 32'd0);
  endtask

  initial begin
    vecs[0]  = mk(7'h33, 3'd0, 32'h1234, 32'h0, 5'd5, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h1234, 1, 1, 0);
    vecs[1]  = mk(7'h33, 3'd0, 32'hCAFE, 32'h0, 5'd0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'hCAFE, 1, 0, 0);
    vecs[2]  = mk(7'h03, 3'd0, 32'h103, 32'h0, 5'd7, 32'h80FF_0000, 1, 1, 0, 4'h8, 32'h0, 32'hFFFF_FF80, 1, 1, 0);
    vecs[3]  = mk(7'h03, 3'd5, 32'h102, 32'h0, 5'd8, 32'hBEEF_0000, 0, 1, 0, 4'hC, 32'h0, 32'h0000_BEEF, 1, 1, 0);
    vecs[4]  = mk(7'h03, 3'd1, 32'h100, 32'h0, 5'd9, 32'h1234_8001, 0, 1, 0, 4'h3, 32'h0, 32'hFFFF_8001, 1, 1, 0);
    vecs[5]  = mk(7'h03, 3'd4, 32'h101, 32'h0, 5'd10, 32'h0000_9A00, 2, 1, 0, 4'h2, 32'h0, 32'h0000_009A, 1, 1, 0);
    vecs[6]  = mk(7'h03, 3'd2, 32'h104, 32'h0, 5'd11, 32'hDEAD_BEEF, 0, 1, 0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1, 1, 0);
    vecs[7]  = mk(7'h23, 3'd1, 32'h202, 32'hAAAA_1234, 5'd3, 32'h0, 1, 1, 1, 4'hC, 32'h1234_1234, 32'h0, 0, 0, 0);
    vecs[8]  = mk(7'h23, 3'd0, 32'h301, 32'h0000_00C5, 5'd4, 32'h0, 0, 1, 1, 4'h2, 32'hC5C5_C5C5, 32'h0, 0, 0, 0);
    vecs[9]  = mk(7'h23, 3'd2, 32'h300, 32'h1122_3344, 5'd0, 32'h0, 0, 1, 1, 4'hF, 32'h1122_3344, 32'h0, 0, 0, 0);
    vecs[10] = mk(7'h03, 3'd2, 32'h101, 32'h0, 5'd12, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 1);
    vecs[11] = mk(7'h03, 3'd1, 32'h103, 32'h0, 5'd13, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 1);
    vecs[12] = mk(7'h03, 3'd0, 32'h100, 32'h0, 5'd0, 32'h0000_007F, 0, 1, 0, 4'h1, 32'h0, 32'h0000_007F, 1, 0, 0);
    vecs[13] = mk(7'h03, 3'd2, 32'h108, 32'h0, 5'd14, 32'h55AA_55AA, 5, 1, 0, 4'hF, 32'h0, 32'h55AA_55AA, 1, 1, 0);
    vecs[14] = mk(7'h23, 3'd2, 32'h302, 32'h1, 5'd0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 1);

    reset = 1'b1; prev_valid_i = 1'b0; next_ready_i = 1'b0;
    opcode_i = 7'h0; funct3_i = 3'd0; result_i = 32'h0; store_data_i = 32'h0; rd_i = 5'd0;
    csr_w_en_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst valid", {31'd0, self_valid_o}, 32'd0);
    check("rst ready", {31'd0, self_ready_o}, 32'd1);
    check("rst req", {31'd0, dmem_req_o}, 32'd0);
    check("rst wb", wb_data_o, 32'd0);
    check("rst wen", {31'd0, reg_w_en_o}, 32'd0);
    check("rst mis", {31'd0, misaligned_o}, 32'd0);
    $display("txn reset: valid=%0d ready=%0d", self_valid_o, self_ready_o);

    for (int i = 0; i < NV; i++) run_vec(i);

    // Backpressure: bundle held for 3 cycles, then back-to-back accept from OUT
    @(negedge clk);
    drive_in(7'h33, 3'd0, 32'hABCD, 32'h0, 5'd6);
    @(negedge clk);
    prev_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("bp valid", {31'd0, self_valid_o}, 32'd1);
      check("bp ready", {31'd0, self_ready_o}, 32'd0);
      check("bp wb", wb_data_o, 32'hABCD);
      check("bp rd", {27'd0, rd_o}, 32'd6);
      check("bp wen", {31'd0, reg_w_en_o}, 32'd1);
      @(negedge clk);
    end
    $display("txn backpressure: wb=%08h held", wb_data_o);
    drive_in(7'h33, 3'd0, 32'h5678, 32'h0, 5'd0);
    next_ready_i = 1'b1;
    @(negedge clk);
    prev_valid_i = 1'b0;
    next_ready_i = 1'b0;
    check("b2b valid", {31'd0, self_valid_o}, 32'd1);
    check("b2b wb", wb_data_o, 32'h5678);
    check("b2b wen", {31'd0, reg_w_en_o}, 32'd0);
    $display("txn back-to-back: wb=%08h wen=%0d", wb_data_o, reg_w_en_o);
    next_ready_i = 1'b1;
    @(negedge clk);
    next_ready_i = 1'b0;

    // Reset while waiting for a response; the late rvalid must be ignored
    drive_in(7'h03, 3'd2, 32'h10C, 32'h0, 5'd15);
    @(negedge clk);
    prev_valid_i = 1'b0;
    check("rr req", {31'd0, dmem_req_o}, 32'd1);
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    check("rr ready_wait", {31'd0, self_ready_o}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rr valid", {31'd0, self_valid_o}, 32'd0);
    check("rr ready", {31'd0, self_ready_o}, 32'd1);
    check("rr req_off", {31'd0, dmem_req_o}, 32'd0);
    check("rr wb", wb_data_o, 32'd0);
    check("rr rd", {27'd0, rd_o}, 32'd0);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    check("late valid", {31'd0, self_valid_o}, 32'd0);
    check("late wb", wb_data_o, 32'd0);
    check("late wen", {31'd0, reg_w_en_o}, 32'd0);
    $display("txn reset-in-wait: valid=%0d wb=%08h", self_valid_o, wb_data_o);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
